// File: rtl/kbd_spi_rx_pkg.sv
// kbd_spi_pkg: shared constants and types for the keyboard SPI receiver.
//   - frame command codes and payload lengths
//   - receiver FSM state encoding
//   - key matrix geometry (8 rows x 5 columns)
package kbd_spi_pkg;

    localparam int ROWS        = 8;
    localparam int COLS        = 5;
    localparam int MATRIX_BITS = ROWS * COLS;

    localparam logic [7:0] CMD_MATRIX = 8'h01;
    localparam logic [7:0] CMD_JOY    = 8'h02;

    localparam logic [2:0] MATRIX_LEN = 3'd5;
    localparam logic [2:0] JOY_LEN    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_SKIP
    } kbd_state_t;

endpackage

// File: rtl/kbd_spi_rx_if.sv
// kbd_spi_rx_if: keyboard link and port #FE read bus.
//   KBD_CS, KBD_CLK, KBD_DI : SPI from the controller (CS active-low, mode 0)
//   A_HI                    : CPU A[15:8], row selects, active-low
//   KD                      : key columns for port #FE bits 4:0, active-low
//   FRAME_OK / FRAME_ERR    : one-cycle frame commit / discard pulses
//   JOY                     : joystick {fire,up,down,left,right}, only when
//                             KBD_SPI_RX_JOY_EN is defined
//   state_dbg               : receiver FSM state, for observation
// Handshake: there is no valid/ready flow control on this link. Each SPI
// bit is accepted on a detected SCK rise while CS is low; a frame's
// contents become visible on KD/JOY only when FRAME_OK pulses.
interface kbd_spi_rx_if;
    import kbd_spi_pkg::*;

    logic       KBD_CS;
    logic       KBD_CLK;
    logic       KBD_DI;
    logic [7:0] A_HI;
    logic [4:0] KD;
    logic       FRAME_OK;
    logic       FRAME_ERR;
`ifdef KBD_SPI_RX_JOY_EN
    logic [4:0] JOY;
`endif
    kbd_state_t state_dbg;

`ifdef KBD_SPI_RX_JOY_EN
    modport master (output KBD_CS, KBD_CLK, KBD_DI, A_HI,
                    input  KD, FRAME_OK, FRAME_ERR, JOY, state_dbg);
    modport slave  (input  KBD_CS, KBD_CLK, KBD_DI, A_HI,
                    output KD, FRAME_OK, FRAME_ERR, JOY, state_dbg);
`else
    modport master (output KBD_CS, KBD_CLK, KBD_DI, A_HI,
                    input  KD, FRAME_OK, FRAME_ERR, state_dbg);
    modport slave  (input  KBD_CS, KBD_CLK, KBD_DI, A_HI,
                    output KD, FRAME_OK, FRAME_ERR, state_dbg);
`endif

endinterface

// File: rtl/kbd_spi_rx_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall detection.
//   clk   : sampling clock
//   din   : asynchronous input
//   level : synchronised level
//   rise  : one-cycle pulse on a synchronised 0->1 transition
//   fall  : one-cycle pulse on a synchronised 1->0 transition
// STAGES must be at least 2.
// The chain has no reset on purpose: it keeps tracking the pin during
// reset, so leaving reset never produces a false edge from a stale value.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_d_q;

    always_ff @(posedge clk) begin
        sync_q    <= {sync_q[STAGES-2:0], din};
        level_d_q <= sync_q[STAGES-1];
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~level_d_q;
    assign fall  = ~level & level_d_q;

endmodule

// File: rtl/kbd_spi_rx.sv
// kbd_spi_rx: SPI slave receiver for the keyboard link, holding the 8x5 ZX
// key matrix and driving KD[4:0] for port #FE reads.
//   CLK_14MHZ : system clock
//   RESET     : synchronous reset, active-high
//   bus       : kbd_spi_rx_if.slave (SPI pins, A_HI, KD, frame pulses)
// Parameters:
//   SYNC_STAGES    : synchroniser depth on CS/SCK/DI (>= 2)
//   TIMEOUT_CYCLES : CLK_14MHZ cycles allowed between SCK rises in a frame
// Optional feature macro: KBD_SPI_RX_JOY_EN adds command 0x02 and bus.JOY.
//
// Frame: command byte, then payload, MSB first. The MATRIX payload is five
// bytes forming one 40-bit word, byte k at bits [8k+7:8k]; row r occupies
// bits [5r+4:5r] and column c of row r is bit 5r+c (0 = pressed). Row 0
// is therefore the low five bits of the first payload byte.
// Payload lands in a shadow buffer and is copied to the live matrix in a
// single cycle when CS rises on a complete frame.
module kbd_spi_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK_14MHZ,
    input  logic       RESET,
    kbd_spi_rx_if.slave bus
);
    import kbd_spi_pkg::*;

    localparam int             TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    // Synchronised inputs and edges
    logic cs_s, cs_rise, cs_fall;
    logic sck_rise, sck_level_unused, sck_fall_unused;
    logic [SYNC_STAGES-1:0] di_sync_q;
    logic di_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (CLK_14MHZ),
        .din   (bus.KBD_CS),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (CLK_14MHZ),
        .din   (bus.KBD_CLK),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall_unused)
    );

    // DI needs no edge detection, only the same latency as SCK.
    always_ff @(posedge CLK_14MHZ) begin
        di_sync_q <= {di_sync_q[SYNC_STAGES-2:0], bus.KBD_DI};
    end
    assign di_s = di_sync_q[SYNC_STAGES-1];

    // State and datapath registers
    kbd_state_t             state_q, state_n;
    logic [2:0]             bit_cnt_q;
    logic [2:0]             byte_cnt_q;
    logic [2:0]             exp_len_q;
    logic [6:0]             shift_q;
    logic [MATRIX_BITS-1:0] shadow_q;
    logic [MATRIX_BITS-1:0] matrix_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   frame_ok_q, frame_err_q;
`ifdef KBD_SPI_RX_JOY_EN
    logic                   joy_sel_q;
    logic [4:0]             joy_q;
`endif

    // Per-cycle decode
    logic       in_frame, frame_start, timeout_hit, take, byte_done;
    logic       cmd_known, cmd_is_joy, commit, abort;
    logic [2:0] bit_pos;
    logic [7:0] byte_val;
    logic [4:0] kd_n;

    assign in_frame    = (state_q == ST_CMD) || (state_q == ST_PAYLOAD);
    assign frame_start = (state_q == ST_IDLE) && cs_fall;
    // A rise on the very cycle the counter expires still counts as in time.
    assign timeout_hit = in_frame && !cs_s && !cs_rise && !sck_rise
                         && (to_cnt_q == TO_MAX);
    // A CS fall and SCK rise in the same cycle: the bit is the command MSB.
    assign take        = sck_rise && !cs_rise && !timeout_hit
                         && (in_frame || frame_start);
    assign bit_pos     = (state_q == ST_IDLE) ? 3'd0 : bit_cnt_q;
    assign byte_val    = {shift_q, di_s};
    assign byte_done   = take && (bit_pos == 3'd7);

`ifdef KBD_SPI_RX_JOY_EN
    assign cmd_is_joy  = (byte_val == CMD_JOY);
    assign cmd_known   = (byte_val == CMD_MATRIX) || cmd_is_joy;
`else
    assign cmd_is_joy  = 1'b0;
    assign cmd_known   = (byte_val == CMD_MATRIX);
`endif

    // FSM state register
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    // FSM next state and commit/abort decisions
    always_comb begin
        state_n = state_q;
        commit  = 1'b0;
        abort   = 1'b0;
        if (cs_rise) begin
            state_n = ST_IDLE;
            if ((state_q == ST_PAYLOAD) && (byte_cnt_q == exp_len_q)
                && (bit_cnt_q == 3'd0))
                commit = 1'b1;
            else if (in_frame)
                abort = 1'b1;
        end else if (timeout_hit) begin
            state_n = ST_SKIP;
            abort   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (cs_fall)   state_n = ST_CMD;
                ST_CMD:  if (byte_done) state_n = cmd_known ? ST_PAYLOAD : ST_SKIP;
                default: ;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge CLK_14MHZ) begin
        if (RESET) begin
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            exp_len_q   <= '0;
            shift_q     <= '0;
            shadow_q    <= '1;
            matrix_q    <= '1;
            to_cnt_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef KBD_SPI_RX_JOY_EN
            joy_sel_q   <= 1'b0;
            joy_q       <= '0;
`endif
        end else begin
            frame_ok_q  <= commit;
            frame_err_q <= abort;

            if (take) shift_q <= byte_val[6:0];

            if (state_q == ST_IDLE) begin
                bit_cnt_q  <= take ? 3'd1 : 3'd0;
                byte_cnt_q <= '0;
            end else if (take) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if ((state_q == ST_CMD) && byte_done && cmd_known) begin
                exp_len_q <= cmd_is_joy ? JOY_LEN : MATRIX_LEN;
`ifdef KBD_SPI_RX_JOY_EN
                joy_sel_q <= cmd_is_joy;
`endif
            end

            // Bytes past the expected length are dropped and mark the
            // frame as over-long so the commit check fails.
            if ((state_q == ST_PAYLOAD) && byte_done) begin
                if (byte_cnt_q < exp_len_q) begin
                    for (int i = 0; i < int'(MATRIX_LEN); i++)
                        if (byte_cnt_q == 3'(i)) shadow_q[8*i +: 8] <= byte_val;
                    byte_cnt_q <= byte_cnt_q + 3'd1;
                end else begin
                    byte_cnt_q <= exp_len_q + 3'd1;
                end
            end

            if (frame_start || abort) shadow_q <= '1;

            if (commit) begin
`ifdef KBD_SPI_RX_JOY_EN
                if (joy_sel_q) joy_q    <= shadow_q[4:0];
                else           matrix_q <= shadow_q;
`else
                matrix_q <= shadow_q;
`endif
            end

            // Saturates so a stalled link cannot wrap into a second timeout.
            if (cs_s || sck_rise || (state_q == ST_IDLE))
                to_cnt_q <= '0;
            else if (to_cnt_q != TO_MAX)
                to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // KD: a column reads 0 if any selected row has that key pressed.
    always_comb begin
        kd_n = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                kd_n[c] = kd_n[c] & (bus.A_HI[r] | matrix_q[r*COLS + c]);
    end

    assign bus.KD        = kd_n;
    assign bus.FRAME_OK  = frame_ok_q;
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.state_dbg = state_q;
`ifdef KBD_SPI_RX_JOY_EN
    assign bus.JOY       = joy_q;
`endif

endmodule

// File: tb/tb_kbd_spi_rx.sv
// tb_kbd_spi_rx: directed bench for kbd_spi_rx. Frame outcome pulses are
// queued as expectations when a frame is driven and matched by a monitor.
module tb_kbd_spi_rx;
    import kbd_spi_pkg::*;

    localparam logic [1:0] EV_OK  = 2'b01;
    localparam logic [1:0] EV_ERR = 2'b10;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [1:0] exp_q[$];
    logic [1:0] mon_want;

    kbd_spi_rx_if bus();

    kbd_spi_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(4096)) dut (
        .CLK_14MHZ (clk),
        .RESET     (rst),
        .bus       (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #35 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.FRAME_OK || bus.FRAME_ERR)) begin
            mon_want = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
            check("pulse", 40'({bus.FRAME_ERR, bus.FRAME_OK}), 40'(mon_want));
        end
    end

    // Driver tasks
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        bus.KBD_DI = b;
        wait_clk(4);
        bus.KBD_CLK = 1'b1;
        wait_clk(4);
        bus.KBD_CLK = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) spi_bit(b[i]);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        bus.KBD_CS = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        bus.KBD_CS = 1'b1;
        wait_clk(12);
        check("pending", 40'(exp_q.size()), 40'd0);
        exp_q.delete();
    endtask

    task automatic send_matrix(input logic [39:0] m);
        cs_begin();
        spi_byte(CMD_MATRIX);
        for (int i = 0; i < 5; i++) spi_byte(m[8*i +: 8]);
        exp_q.push_back(EV_OK);
        cs_end();
    endtask

    task automatic check_kd(input logic [7:0] a, input logic [4:0] exp);
        bus.A_HI = a;
        wait_clk(1);
        check("kd", 40'(bus.KD), 40'(exp));
    endtask

    // Directed sequence
    initial begin
        logic [39:0] m1, m2, m3;
        checks = 0;
        errors = 0;
        m1 = 40'hFF_FF_FF_FF_FE;   // row 0 col 0 pressed
        m2 = 40'h7F_FF_FD_FF_FF;   // row 3 col 2 and row 7 col 4 pressed
        m3 = 40'hFF_C1_FF_FF_FF;   // all of row 5 pressed

        bus.KBD_CS = 1'b1; bus.KBD_CLK = 1'b0; bus.KBD_DI = 1'b0; bus.A_HI = 8'h00;
        rst = 1'b1;
        wait_clk(8);
        rst = 1'b0;
        wait_clk(4);

        // Reset state
        check_kd(8'h00, 5'b11111);
        check("rst_state", 40'(bus.state_dbg), 40'(ST_IDLE));
        check("rst_ok", 40'(bus.FRAME_OK), 40'd0);
        check("rst_err", 40'(bus.FRAME_ERR), 40'd0);
`ifdef KBD_SPI_RX_JOY_EN
        check("rst_joy", 40'(bus.JOY), 40'd0);
`endif

        // Single key, row 0 col 0
        send_matrix(m1);
        check_kd(8'hFE, 5'b11110);
        check_kd(8'hFD, 5'b11111);
        check_kd(8'h00, 5'b11110);
        check_kd(8'hFF, 5'b11111);
        check("idle_after", 40'(bus.state_dbg), 40'(ST_IDLE));

        // Two keys in different rows; exercises packing across bytes
        send_matrix(m2);
        check_kd(8'hF7, 5'b11011);
        check_kd(8'h7F, 5'b01111);
        check_kd(8'h77, 5'b01011);
        check_kd(8'hFE, 5'b11111);
        check_kd(8'h00, 5'b01011);

        // Frame cut after 3 payload bytes
        cs_begin();
        spi_byte(8'h01);
        for (int i = 0; i < 3; i++) spi_byte(8'h00);
        exp_q.push_back(EV_ERR);
        cs_end();
        check_kd(8'h00, 5'b01011);

        // Six payload bytes
        cs_begin();
        spi_byte(8'h01);
        for (int i = 0; i < 6; i++) spi_byte(8'h00);
        exp_q.push_back(EV_ERR);
        cs_end();
        check_kd(8'h00, 5'b01011);

        // Unknown command: silently skipped
        cs_begin();
        spi_byte(8'h55);
        for (int i = 0; i < 5; i++) spi_byte(8'h00);
        cs_end();
        check_kd(8'h00, 5'b01011);

        // CS rise after 4 command bits
        cs_begin();
        spi_bits(8'h01, 4);
        exp_q.push_back(EV_ERR);
        cs_end();
        check_kd(8'h00, 5'b01011);

        // Full payload plus 3 stray bits
        cs_begin();
        spi_byte(8'h01);
        for (int i = 0; i < 5; i++) spi_byte(8'h00);
        spi_bits(8'h00, 3);
        exp_q.push_back(EV_ERR);
        cs_end();
        check_kd(8'h00, 5'b01011);

        // Joystick command
        cs_begin();
        spi_byte(8'h02);
        spi_byte(8'h15);
`ifdef KBD_SPI_RX_JOY_EN
        exp_q.push_back(EV_OK);
        cs_end();
        check("joy", 40'(bus.JOY), 40'h15);
`else
        cs_end();
`endif
        check_kd(8'h00, 5'b01011);

        // Timeout: CS low, SCK stopped
        cs_begin();
        exp_q.push_back(EV_ERR);
        wait_clk(4200);
        check("timeout_pending", 40'(exp_q.size()), 40'd0);
        check("timeout_state", 40'(bus.state_dbg), 40'(ST_SKIP));
        cs_end();
        check_kd(8'h00, 5'b01011);

        // Link recovers
        send_matrix(m3);
        check_kd(8'hDF, 5'b00000);
        check_kd(8'hFF, 5'b11111);
        check_kd(8'hFE, 5'b11111);

        // CS fall and SCK rise together: that bit is the command MSB
        bus.KBD_DI = 1'b0;
        wait_clk(4);
        bus.KBD_CS = 1'b0;
        bus.KBD_CLK = 1'b1;
        wait_clk(4);
        bus.KBD_CLK = 1'b0;
        for (int i = 6; i >= 0; i--) spi_bit(CMD_MATRIX[i]);
        for (int i = 0; i < 5; i++) spi_byte(m1[8*i +: 8]);
        exp_q.push_back(EV_OK);
        cs_end();
        check_kd(8'hFE, 5'b11110);
        check_kd(8'hDF, 5'b11111);

        // Reset mid-frame: frame dropped, no pulses, matrix cleared
        cs_begin();
        spi_byte(8'h01);
        spi_byte(8'hFE);
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) spi_byte(8'h00);
        cs_end();
        check_kd(8'h00, 5'b11111);
        check("rst_mid_state", 40'(bus.state_dbg), 40'(ST_IDLE));

        // Next full frame after the reset
        send_matrix(m2);
        check_kd(8'h77, 5'b01011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
